load_store_unit: RTL and testbench

Data-side load/store unit between the core's memory stage and the data-memory bus. It accepts one load or store per transaction, checks alignment, and generates word-aligned bus requests with byte enables and replicated write data. For loads it returns the addressed byte/half/word shifted down to bit 0, with the size code passed through, ready for the sign/zero-extend stage. It stalls the core with a ready/valid handshake and flags misaligned or timed-out accesses.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 37 +++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-side load/store unit: size codes (also used
// by the extend stage), FSM states and the size-to-access-width decode.
package lsu_pkg;

    localparam logic [2:0] SZ_W  = 3'b000;
    localparam logic [2:0] SZ_B  = 3'b001;
    localparam logic [2:0] SZ_H  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b011;
    localparam logic [2:0] SZ_HU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_width_e;

    // Store codes 011..111 are rejected before this matters; unknown load
    // codes fall through to a word access.
    function automatic acc_width_e access_width(input logic [2:0] size);
        case (size)
            SZ_B, SZ_BU: return ACC_BYTE;
            SZ_H, SZ_HU: return ACC_HALF;
            default:     return ACC_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for one access: bus byte enables, replicated store data
// and the right-shift that brings the addressed load data down to bit 0.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [4:0]  rshift
);

    acc_width_e width;

    assign width  = access_width(size);
    assign rshift = {addr_lo, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            // Loads always fetch the whole word.
            assign be[gi] = !we
                         || (width == ACC_WORD)
                         || (width == ACC_HALF && addr_lo[1] == LANE[1])
                         || (width == ACC_BYTE && addr_lo == LANE);

            assign wdata_rep[8*gi +: 8] = (width == ACC_BYTE) ? wdata[7:0] :
                                          (width == ACC_HALF) ? wdata[8*(gi%2) +: 8] :
                                                                wdata[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Data-side load/store unit: accepts one core access at a time, checks
// alignment, runs a single req/gnt/rvalid bus transaction and reports result.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_we,
    input  logic [2:0]  op_size,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [2:0]  rd_sel,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    lsu_state_e  state_reg, state_next;
    logic [31:0] addr_reg, wdata_reg, rd_data_reg;
    logic        we_reg, err_reg;
    logic [2:0]  size_reg, rd_sel_reg;
    logic [CW-1:0] cnt_reg;

    logic [3:0]  be_al;
    logic [31:0] wdata_al;
    logic [4:0]  rshift_al;
    logic        op_bad, timeout_hit;
    acc_width_e  op_width;

    assign op_width = access_width(op_size);
    assign op_bad   = (op_we && op_size > SZ_H)
                   || (op_width == ACC_HALF && op_addr[0])
                   || (op_width == ACC_WORD && op_addr[1:0] != 2'b00);

    // Counter reaching TIMEOUT-1 in WAIT puts the err pulse TIMEOUT+1 after grant.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

    lsu_align u_align (
        .we        (we_reg),
        .size      (size_reg),
        .addr_lo   (addr_reg[1:0]),
        .wdata     (wdata_reg),
        .be        (be_al),
        .wdata_rep (wdata_al),
        .rshift    (rshift_al)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_ready   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        rd_valid   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_next = op_bad ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req   = 1'b1;
                mem_we    = we_reg;
                mem_be    = be_al;
                mem_addr  = {addr_reg[31:2], 2'b00};
                mem_wdata = we_reg ? wdata_al : 32'd0;
                if (mem_gnt) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rd_valid   = !err_reg && !we_reg;
                done       = !err_reg;
                err        = err_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            size_reg    <= '0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
            rd_data_reg <= '0;
            rd_sel_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (op_valid) begin
                        err_reg <= op_bad;
                        if (!op_bad) begin
                            addr_reg  <= op_addr;
                            we_reg    <= op_we;
                            size_reg  <= op_size;
                            wdata_reg <= op_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        cnt_reg <= '0;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // A response in the timeout cycle still counts as success.
                    if (mem_rvalid) begin
                        if (!we_reg) begin
                            rd_data_reg <= mem_rdata >> rshift_al;
                            rd_sel_reg  <= size_reg;
                        end
                    end else if (timeout_hit) begin
                        err_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign rd_sel  = rd_sel_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit: a byte-level memory model
// predicts responses, a bus responder checks requests, a monitor checks results.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid, op_ready, op_we;
    logic [2:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        rd_valid, done, err;
    logic [31:0] rd_data;
    logic [2:0]  rd_sel;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_we      (op_we),
        .op_size    (op_size),
        .op_addr    (op_addr),
        .op_wdata   (op_wdata),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_sel     (rd_sel),
        .done       (done),
        .err        (err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        bit          is_err;
        bit          is_load;
        logic [31:0] data;
        logic [2:0]  sel;
        int          due;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;
    } req_t;

    resp_t       resp_q[$];
    req_t        req_q[$];
    logic [7:0]  ref_mem [64];
    logic [31:0] bus_mem [16];
    bit          bus_idle = 1'b1;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int nbytes(input logic [2:0] size);
        if (size == 3'd1 || size == 3'd3) return 1;
        if (size == 3'd2 || size == 3'd4) return 2;
        return 4;
    endfunction

    // Issue one op; expectations come from the byte-addressed reference memory.
    task automatic issue(input bit we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gd, input int rd, input bit abort);
        int    n, a, base, waited;
        bit    bad;
        resp_t r;
        req_t  q;
        n    = nbytes(size);
        a    = int'(addr[1:0]);
        base = int'(addr[5:2]) * 4;
        bad  = (we && size > 3'd2) || (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        waited = 0;
        @(negedge clk);
        while (!(op_ready && bus_idle) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            chk(1'b0, "issue_wait_ready", 32'(op_ready), 32'd1);
            return;
        end
        op_valid = 1'b1;
        op_we    = we;
        op_size  = size;
        op_addr  = addr;
        op_wdata = wdata;
        r.is_err  = bad || (rd >= TO);
        r.is_load = !we;
        r.sel     = size;
        r.data    = 32'd0;
        r.due     = cyc + (bad ? 1 : 3 + gd + ((rd < TO - 1) ? rd : TO - 1));
        if (!bad) begin
            q.we      = we;
            q.addr    = {addr[31:2], 2'b00};
            q.be      = we ? 4'b0000 : 4'b1111;
            q.wdata   = 32'd0;
            q.gnt_dly = gd;
            q.rv_dly  = rd;
            if (we) begin
                for (int i = 0; i < n; i++) q.be[a+i] = 1'b1;
                for (int l = 0; l < 4; l++) q.wdata[8*l +: 8] = wdata[8*(l % n) +: 8];
                for (int i = 0; i < n; i++) ref_mem[base+a+i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < 4 - a; i++) r.data[8*i +: 8] = ref_mem[base+a+i];
            end
            req_q.push_back(q);
        end
        if (!abort) resp_q.push_back(r);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Bus responder: grants after gnt_dly, answers rv_dly cycles into WAIT.
    initial begin : bus_model
        req_t        q;
        bit          stable;
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        int          idx;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req) begin
                bus_idle = 1'b0;
                if (req_q.size() == 0) begin
                    chk(1'b0, "unexpected_mem_req", mem_addr, 32'd0);
                    q.we = mem_we; q.addr = mem_addr; q.be = mem_be; q.wdata = mem_wdata;
                    q.gnt_dly = 0; q.rv_dly = 0;
                end else begin
                    q = req_q.pop_front();
                end
                a0 = mem_addr; b0 = mem_be; w0 = mem_wdata; we0 = mem_we;
                stable = 1'b1;
                for (int g = 0; g < q.gnt_dly; g++) begin
                    mem_gnt = 1'b0;
                    @(negedge clk);
                    if (!mem_req || mem_addr !== a0 || mem_be !== b0 || mem_wdata !== w0 || mem_we !== we0)
                        stable = 1'b0;
                end
                if (q.gnt_dly > 0) chk(stable, "req_stable_until_gnt", 32'(stable), 32'd1);
                chk(mem_addr === q.addr, "mem_addr", mem_addr, q.addr);
                chk(mem_be === q.be, "mem_be", 32'(mem_be), 32'(q.be));
                chk(mem_we === q.we, "mem_we", 32'(mem_we), 32'(q.we));
                if (q.we) chk(mem_wdata === q.wdata, "mem_wdata", mem_wdata, q.wdata);
                mem_gnt = 1'b1;
                idx = int'(mem_addr[5:2]);
                if (mem_we) begin
                    for (int l = 0; l < 4; l++)
                        if (mem_be[l]) bus_mem[idx][8*l +: 8] = mem_wdata[8*l +: 8];
                end
                @(negedge clk);
                mem_gnt = 1'b0;
                for (int w = 0; w < q.rv_dly; w++) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = q.we ? $urandom : bus_mem[idx];
                @(negedge clk);
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                bus_idle   = 1'b1;
            end
        end
    end

    initial begin : monitor
        resp_t       r;
        logic [31:0] last_data;
        logic [2:0]  last_sel;
        bit          ready_pend;
        int          nresp;
        last_data = 32'd0; last_sel = 3'd0; ready_pend = 1'b0; nresp = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_data = 32'd0; last_sel = 3'd0; ready_pend = 1'b0;
                continue;
            end
            if (ready_pend) begin
                chk(op_ready === 1'b1, "op_ready_after_resp", 32'(op_ready), 32'd1);
                ready_pend = 1'b0;
            end
            if (done || err || rd_valid) begin
                if (resp_q.size() == 0) begin
                    chk(1'b0, "unexpected_resp", {29'd0, rd_valid, done, err}, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk(err === r.is_err, "err", 32'(err), 32'(r.is_err));
                    chk(done === !r.is_err, "done", 32'(done), 32'(!r.is_err));
                    chk(rd_valid === (!r.is_err && r.is_load), "rd_valid", 32'(rd_valid), 32'(!r.is_err && r.is_load));
                    chk(cyc == r.due, "latency", 32'(cyc), 32'(r.due));
                    chk(op_ready === 1'b0, "op_ready_in_resp", 32'(op_ready), 32'd0);
                    if (!r.is_err && r.is_load) begin
                        last_data = r.data;
                        last_sel  = r.sel;
                    end
                    chk(rd_data === last_data, "rd_data", rd_data, last_data);
                    chk(rd_sel === last_sel, "rd_sel", 32'(rd_sel), 32'(last_sel));
                    ready_pend = 1'b1;
                    $display("resp %0d: cycle %0d %s err=%0b rd_data=0x%08h rd_sel=%0d",
                             nresp, cyc, r.is_load ? "load " : "store", err, rd_data, rd_sel);
                    nresp++;
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] w, addr;
        logic [2:0]  size;
        bit          we;
        int          waited;
        op_valid = 1'b0; op_we = 1'b0; op_size = 3'd0; op_addr = 32'd0; op_wdata = 32'd0;
        for (int i = 0; i < 16; i++) begin
            w = (i == 0) ? 32'hAABBCCDD : $urandom;
            bus_mem[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
        end
        repeat (3) @(negedge clk);
        chk(op_ready === 1'b1, "reset_op_ready", 32'(op_ready), 32'd1);
        chk({mem_req, mem_we, rd_valid, done, err} === 5'b0, "reset_pulses",
            32'({mem_req, mem_we, rd_valid, done, err}), 32'd0);
        chk(mem_be === 4'b0000, "reset_mem_be", 32'(mem_be), 32'd0);
        chk((mem_addr | mem_wdata | rd_data) === 32'd0, "reset_data_buses", mem_addr | mem_wdata | rd_data, 32'd0);
        chk(rd_sel === 3'd0, "reset_rd_sel", 32'(rd_sel), 32'd0);
        #2 rst_n = 1'b1;

        issue(1'b0, SZ_B,   32'h0000_1003, 32'd0,          0, 0, 1'b0);
        issue(1'b1, SZ_H,   32'h0000_2002, 32'h0000_1234,  0, 0, 1'b0);
        issue(1'b0, SZ_W,   32'h0000_3001, 32'd0,          0, 0, 1'b0);
        issue(1'b1, 3'b011, 32'h0000_4000, 32'h5555_5555,  0, 0, 1'b0);
        issue(1'b0, SZ_W,   32'h0000_5004, 32'd0,          5, 1, 1'b0);
        issue(1'b0, SZ_HU,  32'h0000_6006, 32'd0,          1, TO - 1, 1'b0);
        issue(1'b0, SZ_W,   32'h0000_7008, 32'd0,          0, TO + 2, 1'b0);
        issue(1'b1, SZ_W,   32'h0000_800C, 32'hDEAD_BEEF,  2, TO + 1, 1'b0);
        issue(1'b0, SZ_W,   32'h0000_800C, 32'd0,          0, 0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            we   = 1'($urandom_range(0, 1));
            size = we ? (($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)))
                      : 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(size) - 1);
            issue(we, size, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, TO + 1), 1'b0);
        end

        // Abandon a load in WAIT with an asynchronous reset.
        issue(1'b0, SZ_W, 32'h0000_9000, 32'd0, 0, 20, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk(mem_req === 1'b0, "async_reset_mem_req", 32'(mem_req), 32'd0);
        chk(op_ready === 1'b1, "async_reset_op_ready", 32'(op_ready), 32'd1);
        chk(rd_data === 32'd0, "async_reset_rd_data", rd_data, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        issue(1'b1, SZ_B, 32'h0000_A001, 32'h0000_0077, 1, 0, 1'b0);
        issue(1'b0, SZ_BU, 32'h0000_A001, 32'd0, 0, 0, 1'b0);

        waited = 0;
        while ((resp_q.size() != 0 || !bus_idle) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        chk(resp_q.size() == 0, "resp_queue_drained", 32'(resp_q.size()), 32'd0);
        chk(req_q.size() == 0, "req_queue_drained", 32'(req_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
